// File: rtl/alu_16bit.sv
// 16-bit execute-stage ALU: 16 bitwise logic functions, 8 add/subtract
// functions with carry-in, and 1-bit logical shifts. {Cout,F} is registered,
// so a result appears one clock after its operands and select are sampled.
module alu_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Cin,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [4:0]  FS,
    output logic [15:0] F,
    output logic        Cout
);

    // Function group decoded from FS[4:3]
    localparam logic [1:0] GRP_LOGIC_LO = 2'b00;
    localparam logic [1:0] GRP_LOGIC_HI = 2'b01;
    localparam logic [1:0] GRP_ARITH    = 2'b10;
    localparam logic [1:0] GRP_SHIFT    = 2'b11;

    // Bitwise logic functions; carry-out is always zero for this group
    function automatic logic [15:0] logic_fn(
        input logic [3:0]  sel,
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [15:0] y;
        y = 16'h0000;
        case (sel)
            4'b0000: y = 16'h0000;
            4'b0001: y = ~(a | b);
            4'b0010: y = ~a & b;
            4'b0011: y = ~a;
            4'b0100: y = a & ~b;
            4'b0101: y = ~b;
            4'b0110: y = a ^ b;
            4'b0111: y = ~(a & b);
            4'b1000: y = a & b;
            4'b1001: y = ~(a ^ b);
            4'b1010: y = b;
            4'b1011: y = ~a | b;
            4'b1100: y = a;
            4'b1101: y = a | ~b;
            4'b1110: y = a | b;
            4'b1111: y = 16'hFFFF;
            default: y = 16'h0000;
        endcase
        return y;
    endfunction

    // Add/subtract group: choose the two 16-bit terms and the carry bit, then
    // form one 17-bit unsigned sum so the top bit is the carry-out.
    function automatic logic [16:0] arith_fn(
        input logic [2:0]  sel,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        cin
    );
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        x = a;
        y = 16'h0000;
        c = cin;
        case (sel)
            3'b000: begin x = a;  y = 16'h0000; c = cin;  end // A + Cin
            3'b001: begin x = ~a; y = 16'h0000; c = 1'b1; end // two's complement negate
            3'b010: begin x = a;  y = 16'h0001; c = cin;  end // A + 1 + Cin
            3'b011: begin x = ~a; y = 16'h0001; c = cin;  end // Cin - A
            3'b100: begin x = a;  y = b;        c = cin;  end // A + B + Cin
            3'b101: begin x = ~a; y = b;        c = cin;  end // ~A + B + Cin
            3'b110: begin x = a;  y = ~b;       c = cin;  end // A - B - 1 + Cin
            3'b111: begin x = ~a; y = ~b;       c = cin;  end // ~A + ~B + Cin
            default: begin x = a; y = 16'h0000; c = cin;  end
        endcase
        return {1'b0, x} + {1'b0, y} + {16'h0000, c};
    endfunction

    // One-bit shifts; the bit shifted out becomes the carry-out
    function automatic logic [16:0] shift_fn(
        input logic        dir_right,
        input logic [15:0] a,
        input logic        cin
    );
        logic [16:0] y;
        if (dir_right) begin
            y = {a[0], 1'b0, a[15:1]};
        end else begin
            y = {a[15], a[14:0], cin};
        end
        return y;
    endfunction

    logic [16:0] w_result;
    logic [15:0] r_f;
    logic        r_cout;

    // Select the combinational {carry, result} for the current function code
    always_comb begin
        w_result = 17'h00000;
        case (FS[4:3])
            GRP_LOGIC_LO: w_result = {1'b0, logic_fn(FS[3:0], A, B)};
            GRP_LOGIC_HI: w_result = {1'b0, logic_fn(FS[3:0], A, B)};
            GRP_ARITH:    w_result = arith_fn(FS[2:0], A, B, Cin);
            GRP_SHIFT:    w_result = shift_fn(FS[0], A, Cin);
            default:      w_result = 17'h00000;
        endcase
    end

    // Output register with synchronous active-low clear taking priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f    <= 16'h0000;
            r_cout <= 1'b0;
        end else begin
            r_f    <= w_result[15:0];
            r_cout <= w_result[16];
        end
    end

    assign F    = r_f;
    assign Cout = r_cout;

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: directed cases plus a randomized sweep
// against a truth-table / integer-arithmetic reference model.
module tb_alu_16bit;

    logic        clk;
    logic        rst_n;
    logic        Cin;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  FS;
    logic [15:0] F;
    logic        Cout;

    int n_checks;
    int n_fail;

    alu_16bit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Cin  (Cin),
        .A    (A),
        .B    (B),
        .FS   (FS),
        .F    (F),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. Logic group: FS[3:0] is the truth table of the bitwise
    // function indexed by {a,b}. Other groups use plain integer arithmetic.
    function automatic logic [16:0] ref_model(input logic [4:0] fs, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin);
        logic [3:0]  tt;
        logic [15:0] f;
        int ia, ib, na, nb, ic, s;
        logic [16:0] r;
        ia = int'(a); ib = int'(b);
        na = 65535 - ia; nb = 65535 - ib;
        ic = cin ? 1 : 0;
        s  = 0;
        r  = 17'h00000;
        if (fs[4] == 1'b0) begin
            tt = fs[3:0];
            for (int i = 0; i < 16; i++) f[i] = tt[{a[i], b[i]}];
            r = {1'b0, f};
        end else if (fs[3] == 1'b0) begin
            case (fs[2:0])
                3'd0: s = ia + ic;
                3'd1: s = na + 1;
                3'd2: s = ia + 1 + ic;
                3'd3: s = na + 1 + ic;
                3'd4: s = ia + ib + ic;
                3'd5: s = na + ib + ic;
                3'd6: s = ia + nb + ic;
                default: s = na + nb + ic;
            endcase
            r = s[16:0];
        end else if (fs[0] == 1'b0) begin
            s = ia * 2 + ic;
            r = s[16:0];
        end else begin
            s = ia / 2;
            r = {a[0], s[15:0]};
        end
        return r;
    endfunction

    // Apply inputs away from the edge, clock once, settle past the edge
    task automatic step(input logic rn, input logic [4:0] fs, input logic [15:0] a,
                        input logic [15:0] b, input logic cin);
        rst_n = rn; FS = fs; A = a; B = b; Cin = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 5'b01111, 16'hFFFF, 16'h0000, 1'b0);
        n_checks++;
        if ({Cout, F} !== 17'h00000) begin
            n_fail++;
            $display("FAIL reset_clear: got Cout=%b F=%h, want Cout=0 F=0000", Cout, F);
        end
        step(1'b1, 5'b01111, 16'hFFFF, 16'h0000, 1'b0);
        n_checks++;
        if ({Cout, F} !== 17'h0FFFF) begin
            n_fail++;
            $display("FAIL reset_release: got Cout=%b F=%h, want Cout=0 F=ffff", Cout, F);
        end
    endtask

    task automatic test_logic();
        logic [4:0]  fs_t [3]  = '{5'b00110, 5'b01000, 5'b00001};
        logic [15:0] exp_t [3] = '{16'h12CB, 16'h0034, 16'hED00};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, fs_t[i], 16'h1234, 16'h00FF, 1'b1);
            n_checks++;
            if ({Cout, F} !== {1'b0, exp_t[i]}) begin
                n_fail++;
                $display("FAIL logic_fs%b: got Cout=%b F=%h, want Cout=0 F=%h", fs_t[i], Cout, F, exp_t[i]);
            end
        end
    endtask

    task automatic test_arith();
        logic [4:0]  fs_t [5]  = '{5'b10100, 5'b10001, 5'b10011, 5'b10110, 5'b10000};
        logic [15:0] a_t  [5]  = '{16'hFFFF, 16'h0000, 16'h0005, 16'h0005, 16'hFFFF};
        logic [15:0] b_t  [5]  = '{16'h0001, 16'h0001, 16'h0000, 16'h0003, 16'h0000};
        logic [16:0] exp_t [5] = '{17'h10001, 17'h10000, 17'h0FFFC, 17'h10002, 17'h10000};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, fs_t[i], a_t[i], b_t[i], 1'b1);
            n_checks++;
            if ({Cout, F} !== exp_t[i]) begin
                n_fail++;
                $display("FAIL arith_fs%b: got {Cout,F}=%h, want %h", fs_t[i], {Cout, F}, exp_t[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [4:0]  fs_t [4]  = '{5'b11000, 5'b11111, 5'b11010, 5'b11001};
        logic [16:0] exp_t [4] = '{17'h10003, 17'h14000, 17'h10003, 17'h14000};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, fs_t[i], 16'h8001, 16'h5A5A, 1'b1);
            n_checks++;
            if ({Cout, F} !== exp_t[i]) begin
                n_fail++;
                $display("FAIL shift_fs%b: got {Cout,F}=%h, want %h", fs_t[i], {Cout, F}, exp_t[i]);
            end
        end
    endtask

    // Reset in the middle of a stream, then release with fresh inputs
    task automatic test_reset_midstream();
        step(1'b1, 5'b10100, 16'h1111, 16'h2222, 1'b0);
        step(1'b0, 5'b10100, 16'h1111, 16'h2222, 1'b0);
        n_checks++;
        if ({Cout, F} !== 17'h00000) begin
            n_fail++;
            $display("FAIL reset_midstream: got {Cout,F}=%h, want 00000", {Cout, F});
        end
        step(1'b1, 5'b00111, 16'hF0F0, 16'hFF00, 1'b0);
        n_checks++;
        if ({Cout, F} !== 17'h00FFF) begin
            n_fail++;
            $display("FAIL reset_release_mid: got {Cout,F}=%h, want 00fff", {Cout, F});
        end
    endtask

    // Random operands across all 32 codes back-to-back; also confirm the
    // registered outputs do not follow input changes between edges.
    task automatic test_random_sweep();
        logic [15:0] a, b;
        logic        c;
        logic [16:0] exp_v;
        for (int r = 0; r < 10; r++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            for (int f = 0; f < 32; f++) begin
                exp_v = ref_model(5'(f), a, b, c);
                step(1'b1, 5'(f), a, b, c);
                n_checks++;
                if ({Cout, F} !== exp_v) begin
                    n_fail++;
                    $display("FAIL sweep_fs%0d a=%h b=%h cin=%b: got {Cout,F}=%h, want %h",
                             f, a, b, c, {Cout, F}, exp_v);
                end
                A = ~a; B = ~b; Cin = ~c; FS = 5'(f) ^ 5'b10101;
                #2;
                n_checks++;
                if ({Cout, F} !== exp_v) begin
                    n_fail++;
                    $display("FAIL hold_fs%0d: got {Cout,F}=%h, want %h", f, {Cout, F}, exp_v);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; Cin = 1'b0; A = 16'h0000; B = 16'h0000; FS = 5'b00000;
        #2;
        test_reset();
        test_logic();
        test_arith();
        test_shift();
        test_reset_midstream();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
